// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// The bus FSM states, the two access owners and the memory_select encodings.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } bus_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam logic MEMSEL_PROG = 1'b0;
    localparam logic MEMSEL_DATA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant between fetch and data requesters.
// last_grant advances only when the bus FSM accepts the current grant.
import cpu_bus_pkg::*;

module rr_arb2 (
    input  logic   clk,
    input  logic   reset,
    input  logic   req_fetch,
    input  logic   req_data,
    input  logic   accept,
    output logic   grant_valid,
    output owner_t grant
);

    owner_t last_grant;

    always_comb begin
        grant_valid = req_fetch | req_data;
        grant       = FETCH;
        if (req_fetch && req_data) begin
            // On a tie the requester that was not served last wins.
            grant = (last_grant == FETCH) ? DATA : FETCH;
        end else if (req_data) begin
            grant = DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= FETCH;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Shares the single external memory bus between instruction fetch and MOVX data,
// sequencing each access through ADDR, STROBE (WAIT_CYCLES) and DONE phases.
import cpu_bus_pkg::*;

module ext_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              read_en,
    output logic              write_en,
    output logic              psen,
    output logic              memory_select
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    bus_state_t        state, state_next;
    owner_t            owner_r;
    owner_t            grant;
    logic              grant_valid;
    logic              accept;
    logic              we_r;
    logic              memsel_r;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;

    assign accept = (state == IDLE) && grant_valid;

    rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_fetch   (if_req),
        .req_data    (dm_req),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ADDR;
            ADDR:    state_next = STROBE;
            STROBE:  if (cnt == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r    <= FETCH;
            we_r       <= 1'b0;
            memsel_r   <= MEMSEL_PROG;
            cnt        <= 4'd0;
            addr_r     <= '0;
            wdata_r    <= '0;
            if_rdata_r <= '0;
            dm_rdata_r <= '0;
        end else begin
            if (accept) begin
                owner_r  <= grant;
                we_r     <= (grant == DATA) && dm_we;
                memsel_r <= (grant == DATA) ? MEMSEL_DATA : MEMSEL_PROG;
                addr_r   <= (grant == DATA) ? dm_addr : if_addr;
                if (grant == DATA) wdata_r <= dm_wdata;
            end
            if (state == ADDR) begin
                cnt <= CNT_LOAD;
            end else if (state == STROBE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Read data is captured at the end of the last strobe cycle.
            if (state == STROBE && cnt == 4'd0 && !we_r) begin
                if (owner_r == FETCH) if_rdata_r <= data_in;
                else                  dm_rdata_r <= data_in;
            end
        end
    end

    always_comb begin
        psen     = 1'b0;
        read_en  = 1'b0;
        write_en = 1'b0;
        data_oe  = 1'b0;
        if_ack   = 1'b0;
        dm_ack   = 1'b0;
        case (state)
            ADDR: begin
                data_oe = we_r;
            end
            STROBE: begin
                data_oe  = we_r;
                psen     = (owner_r == FETCH);
                read_en  = (owner_r == DATA) && !we_r;
                write_en = (owner_r == DATA) && we_r;
            end
            DONE: begin
                if_ack = (owner_r == FETCH);
                dm_ack = (owner_r == DATA);
            end
            default: ;
        endcase
    end

    assign addr_bus      = addr_r;
    assign data_out      = wdata_r;
    assign memory_select = memsel_r;
    assign if_rdata      = if_rdata_r;
    assign dm_rdata      = dm_rdata_r;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: a WAIT_CYCLES=2 instance for most scenarios
// and a WAIT_CYCLES=1 instance for the short-strobe case.
module tb_ext_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [15:0] if_addr = '0, dm_addr = '0, addr_bus;
    logic [7:0]  dm_wdata = '0, data_in = '0, if_rdata, dm_rdata, data_out;
    logic        if_ack, dm_ack, data_oe, read_en, write_en, psen, memory_select;

    logic        w1_if_req = 1'b0, w1_dm_req = 1'b0, w1_dm_we = 1'b0;
    logic [15:0] w1_if_addr = '0, w1_dm_addr = '0, w1_addr_bus;
    logic [7:0]  w1_dm_wdata = '0, w1_data_in = '0, w1_if_rdata, w1_dm_rdata, w1_data_out;
    logic        w1_if_ack, w1_dm_ack, w1_data_oe, w1_read_en, w1_write_en, w1_psen, w1_memory_select;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ext_bus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .addr_bus(addr_bus), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .read_en(read_en), .write_en(write_en), .psen(psen), .memory_select(memory_select)
    );

    ext_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(8)) dut_w1 (
        .clk(clk), .reset(reset),
        .if_req(w1_if_req), .if_addr(w1_if_addr), .if_ack(w1_if_ack), .if_rdata(w1_if_rdata),
        .dm_req(w1_dm_req), .dm_we(w1_dm_we), .dm_addr(w1_dm_addr), .dm_wdata(w1_dm_wdata),
        .dm_ack(w1_dm_ack), .dm_rdata(w1_dm_rdata),
        .addr_bus(w1_addr_bus), .data_out(w1_data_out), .data_oe(w1_data_oe), .data_in(w1_data_in),
        .read_en(w1_read_en), .write_en(w1_write_en), .psen(w1_psen), .memory_select(w1_memory_select)
    );

    // Advance one cycle; outputs are observed 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({psen, read_en, write_en, data_oe, if_ack, dm_ack, memory_select} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {psen, read_en, write_en, data_oe, if_ack, dm_ack, memory_select});
        end
        tests_run++;
        if ({addr_bus, data_out, if_rdata, dm_rdata} !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h required 0", {addr_bus, data_out, if_rdata, dm_rdata});
        end
        tests_run++;
        if ({w1_psen, w1_read_en, w1_write_en, w1_data_oe, w1_if_ack, w1_dm_ack, w1_memory_select,
             w1_addr_bus} !== 23'h0) begin
            tests_failed++;
            $display("FAIL reset_w1: got nonzero outputs on WAIT_CYCLES=1 instance");
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous;
        int n_acks;
        int ack_at[3];
        logic ack_own[3];
        logic both_ack;
        logic ms1, ms6;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_acks = 0;
        both_ack = 1'b0;
        ms1 = 1'b0;
        ms6 = 1'b1;
        if_addr = 16'h0010;
        dm_addr = 16'h8010;
        dm_we   = 1'b0;
        data_in = 8'h77;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) ms1 = memory_select;
            if (k == 6) ms6 = memory_select;
            if (if_ack && dm_ack) both_ack = 1'b1;
            if ((if_ack || dm_ack) && n_acks < 3) begin
                ack_at[n_acks]  = k;
                ack_own[n_acks] = dm_ack;
                n_acks++;
                if (n_acks == 3) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        tests_run++;
        if (n_acks != 3 || both_ack) begin
            tests_failed++;
            $display("FAIL tie_ack_count: got %0d acks (overlap=%0b) required 3", n_acks, both_ack);
        end else begin
            tests_run++;
            if ({ack_own[0], ack_own[1], ack_own[2]} !== 3'b101) begin
                tests_failed++;
                $display("FAIL tie_order: got %b required 101 (DATA,FETCH,DATA)",
                         {ack_own[0], ack_own[1], ack_own[2]});
            end
            tests_run++;
            if (ack_at[0] != 4 || ack_at[1] != 9 || ack_at[2] != 14) begin
                tests_failed++;
                $display("FAIL tie_spacing: got acks at %0d,%0d,%0d required 4,9,14",
                         ack_at[0], ack_at[1], ack_at[2]);
            end
        end
        tests_run++;
        if (ms1 !== 1'b1 || ms6 !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_memsel: got %b%b required 10", ms1, ms6);
        end
    endtask

    task automatic test_single_fetch;
        int psen_n, ack_n, ack_at;
        logic bad_strobe, addr_ok;
        logic [7:0] rd;
        psen_n = 0; ack_n = 0; ack_at = -1;
        bad_strobe = 1'b0; addr_ok = 1'b1; rd = 8'h00;
        if_addr = 16'h0123;
        data_in = 8'h0A;
        if_req  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (psen) psen_n++;
            if (read_en || write_en || data_oe || dm_ack) bad_strobe = 1'b1;
            if (k <= 4 && (addr_bus !== 16'h0123 || memory_select !== 1'b0)) addr_ok = 1'b0;
            if (if_ack) begin
                ack_n++;
                ack_at = k;
                rd = if_rdata;
                if_req = 1'b0;
            end
        end
        tests_run++;
        if (psen_n != 2) begin
            tests_failed++;
            $display("FAIL fetch_psen_len: got %0d cycles required 2", psen_n);
        end
        tests_run++;
        if (ack_n != 1 || ack_at != 4) begin
            tests_failed++;
            $display("FAIL fetch_ack: got %0d acks at cycle %0d required 1 at 4", ack_n, ack_at);
        end
        tests_run++;
        if (rd !== 8'h0A || if_rdata !== 8'h0A) begin
            tests_failed++;
            $display("FAIL fetch_rdata: got %h/%h required 0a", rd, if_rdata);
        end
        tests_run++;
        if (!addr_ok || bad_strobe) begin
            tests_failed++;
            $display("FAIL fetch_bus: addr/memsel ok=%0b stray strobe=%0b required 1/0", addr_ok, bad_strobe);
        end
    endtask

    task automatic test_data_write;
        int we_n, oe_n, ack_n, ack_at;
        logic oe_ok, bad_strobe, ms_ok;
        we_n = 0; oe_n = 0; ack_n = 0; ack_at = -1;
        oe_ok = 1'b1; bad_strobe = 1'b0; ms_ok = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h8000;
        dm_wdata = 8'h5A;
        dm_req   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (write_en) we_n++;
            if (data_oe) oe_n++;
            if (k <= 3 && (data_oe !== 1'b1 || data_out !== 8'h5A)) oe_ok = 1'b0;
            if (k <= 4 && (memory_select !== 1'b1 || addr_bus !== 16'h8000)) ms_ok = 1'b0;
            if (read_en || psen || if_ack) bad_strobe = 1'b1;
            if (dm_ack) begin
                ack_n++;
                ack_at = k;
                dm_req = 1'b0;
            end
        end
        dm_we = 1'b0;
        tests_run++;
        if (we_n != 2) begin
            tests_failed++;
            $display("FAIL write_strobe_len: got %0d cycles required 2", we_n);
        end
        tests_run++;
        if (!oe_ok || oe_n != 3) begin
            tests_failed++;
            $display("FAIL write_data_oe: got %0d oe cycles (setup ok=%0b) required 3", oe_n, oe_ok);
        end
        tests_run++;
        if (ack_n != 1 || ack_at != 4 || !ms_ok || bad_strobe) begin
            tests_failed++;
            $display("FAIL write_ack_bus: got %0d acks at %0d ms_ok=%0b stray=%0b required 1 at 4, 1, 0",
                     ack_n, ack_at, ms_ok, bad_strobe);
        end
    endtask

    task automatic test_withdraw_late_drop;
        int dm_ack_n, if_ack_n, psen_n;
        dm_ack_n = 0; if_ack_n = 0; psen_n = 0;
        dm_we   = 1'b0;
        dm_addr = 16'h9001;
        data_in = 8'h33;
        dm_req  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) if_req = 1'b1;
            if (k == 2) if_req = 1'b0;
            if (k == 2) dm_req = 1'b0;
            if (psen) psen_n++;
            if (if_ack) if_ack_n++;
            if (dm_ack) dm_ack_n++;
        end
        tests_run++;
        if (psen_n != 0 || if_ack_n != 0) begin
            tests_failed++;
            $display("FAIL withdraw: got psen=%0d if_ack=%0d required 0 0", psen_n, if_ack_n);
        end
        tests_run++;
        if (dm_ack_n != 1 || dm_rdata !== 8'h33) begin
            tests_failed++;
            $display("FAIL late_drop: got %0d dm_ack rdata=%h required 1 33", dm_ack_n, dm_rdata);
        end
    endtask

    task automatic test_reset_mid_strobe;
        int ack_n, fetch_at;
        logic saw_we;
        ack_n = 0; fetch_at = -1; saw_we = 1'b0;
        dm_we    = 1'b1;
        dm_addr  = 16'h8100;
        dm_wdata = 8'hA5;
        dm_req   = 1'b1;
        tick();
        tick();
        saw_we = write_en;
        reset  = 1'b1;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        tests_run++;
        if (saw_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_setup: got write_en=%b required 1 before reset", saw_we);
        end
        tests_run++;
        if ({write_en, read_en, psen, data_oe, dm_ack, if_ack} !== 6'b0) begin
            tests_failed++;
            $display("FAIL abort_strobes: got %b required 000000",
                     {write_en, read_en, psen, data_oe, dm_ack, if_ack});
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dm_ack) ack_n++;
        end
        tests_run++;
        if (ack_n != 0) begin
            tests_failed++;
            $display("FAIL abort_no_ack: got %0d dm_ack required 0", ack_n);
        end
        if_addr = 16'h0456;
        data_in = 8'hC3;
        if_req  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (if_ack && fetch_at < 0) begin
                fetch_at = k;
                if_req = 1'b0;
            end
        end
        tests_run++;
        if (fetch_at != 4 || if_rdata !== 8'hC3) begin
            tests_failed++;
            $display("FAIL post_reset_fetch: got ack at %0d rdata=%h required 4 c3", fetch_at, if_rdata);
        end
    endtask

    task automatic test_wait1;
        int re_n, ack_n, ack_at;
        re_n = 0; ack_n = 0; ack_at = -1;
        w1_dm_we   = 1'b0;
        w1_dm_addr = 16'h1234;
        w1_data_in = 8'h3C;
        w1_dm_req  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (w1_read_en) re_n++;
            if (w1_dm_ack) begin
                ack_n++;
                ack_at = k;
                w1_dm_req = 1'b0;
            end
        end
        tests_run++;
        if (re_n != 1) begin
            tests_failed++;
            $display("FAIL w1_read_len: got %0d cycles required 1", re_n);
        end
        tests_run++;
        if (ack_n != 1 || ack_at != 3 || w1_dm_rdata !== 8'h3C) begin
            tests_failed++;
            $display("FAIL w1_ack: got %0d acks at %0d rdata=%h required 1 at 3 3c", ack_n, ack_at, w1_dm_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_fetch();
        test_data_write();
        test_withdraw_late_drop();
        test_reset_mid_strobe();
        test_wait1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ext_bus_arbiter.md
Name: ext_bus_arbiter

Overview:
- Shares the CPU's single external memory bus between two requesters: the instruction-fetch unit (program memory) and the MOVX data unit (external data memory).
- Arbitrates between them, sequences each access through address, strobe and completion phases with a programmable number of wait states, and returns read data with a one-cycle acknowledge.
- Sits between the CPU core and the pins addr_bus, data_bus, read_en, write_en, PSEN and memory_select.

Parameters:
- WAIT_CYCLES, 2, number of cycles the read/write strobe is held; legal range 1..15.
- ADDR_W, 16, external address width.
- DATA_W, 8, external data width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete, if_rdata valid in the same cycle.
- if_rdata  out  DATA_W  fetched byte; holds its value until the next fetch completes.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle pulse; data access complete.
- dm_rdata  out  DATA_W  read byte; valid with dm_ack on reads, held otherwise.
- addr_bus  out  ADDR_W  external address.
- data_out  out  DATA_W  value driven onto data_bus during writes.
- data_oe  out  1  tristate enable for data_out.
- data_in  in  DATA_W  value sampled from data_bus.
- read_en  out  1  data-memory read strobe.
- write_en  out  1  data-memory write strobe.
- psen  out  1  program-memory read strobe, active-high internally.
- memory_select  out  1  0 = program space, 1 = data space.

Behaviour:
- Reset: every output is 0, all registers are cleared, FSM goes to IDLE, last_grant = FETCH. Reset mid-access aborts the access: strobes are 0 from the next edge and no ack is issued.
- FSM states are IDLE, ADDR, STROBE and DONE.
- IDLE:
  - Samples if_req and dm_req.
  - If only one is high, grant it.
  - If both are high, grant the one not equal to last_grant (round-robin). After reset, data wins the first tie.
  - On grant, register addr, we, wdata and the grant owner; set last_grant; go to ADDR.
  - If neither is high, stay in IDLE.
- ADDR (1 cycle):
  - Drive addr_bus and memory_select; all strobes 0.
  - For writes, also drive data_out and set data_oe = 1 (address and data setup before the strobe).
  - Load wait counter = WAIT_CYCLES-1.
- STROBE (WAIT_CYCLES cycles):
  - Assert exactly one strobe: psen for a fetch, read_en for a data read, write_en for a data write.
  - Address, memory_select and, for writes, data_out/data_oe stay stable.
  - The counter decrements each cycle. When it reaches 0, capture data_in into the owner's rdata register (reads only) and go to DONE.
- DONE (1 cycle):
  - Strobes 0. addr_bus is held. data_oe = 0.
  - Pulse the owner's ack.
  - Go to IDLE.
- Latency: with a request accepted in cycle t, ack is high in cycle t+2+WAIT_CYCLES. The minimum period between back-to-back accesses is 3+WAIT_CYCLES cycles.
- Request handshake:
  - Dropping req while the block is in IDLE withdraws it and no access occurs.
  - Dropping req after the grant is ignored; the access completes and is acked.
  - A request that is not granted keeps waiting with no timeout. Round-robin guarantees service within one other transaction.
- Fetch accesses never assert write_en or data_oe. read_en and psen are never high together.
- The wait counter is 4 bits. With WAIT_CYCLES = 1, STROBE lasts exactly 1 cycle.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - the enum typedef bus_state_t (IDLE, ADDR, STROBE, DONE);
  - the enum typedef owner_t (FETCH, DATA);
  - constants MEMSEL_PROG = 0 and MEMSEL_DATA = 1.
- Natural sub-module: rr_arb2, a two-input round-robin grant with a last_grant register and an update-on-accept input. The FSM, counter and datapath stay in the top module.

Test Plan (WAIT_CYCLES = 2):
- Single fetch: if_req=1, if_addr=0x0123, data_in=0x0A. Required: psen high for 2 cycles; addr_bus=0x0123; memory_select=0; if_ack is a single pulse 4 cycles after acceptance; if_rdata=0x0A.
- Data write: dm_req=1, dm_we=1, dm_addr=0x8000, dm_wdata=0x5A. Required: data_oe=1 and data_out=0x5A from ADDR through STROBE; write_en high for 2 cycles; memory_select=1; dm_ack pulsed; read_en and psen stay 0.
- Simultaneous requests just after reset: data is served first, then the fetch. With both held continuously, grants alternate DATA, FETCH, DATA, and each ack is spaced 5 cycles apart.
- Withdrawal and late drop: if_req raised and dropped before it is granted (data busy) gives no psen and no ack. dm_req dropped during STROBE still yields dm_ack.
- Reset asserted in the middle of STROBE: on the next edge all strobes are 0, data_oe=0 and no ack is issued. After reset is released, a new fetch completes normally.
- WAIT_CYCLES=1 build: a data read of 0x3C completes with read_en high for 1 cycle, and dm_ack arrives 3 cycles after acceptance.
